unidad_control: RTL and testbench
=================================

// Module: unidad_control
// PURPOSE
//   Multi-cycle FSM sequencer for the 8-bit micro. Fetches 9-bit instructions {op[8:6],RX[5:3],RY[2:0]}
//   from synchronous program ROM and presents each to the 8x8 register bank for its execute window.
//   Also drives the data-memory req/ack handshake, the ALU write-back strobe into R0, and PC update
//   (increment, jump, call). Sits between program ROM, register bank, ALU and data memory.
// PARAMETERS
//   PC_W        8    program counter width; PC wraps modulo 2**PC_W
//   RESET_PC    0    PC value loaded on reset
//   MEM_TIMEOUT 15   max MEM_WAIT cycles without i_Mem_Ack before fault (1..255)
// PORTS
//   i_Clk          in   1     clock, rising edge
//   i_Rst          in   1     reset, synchronous, active-high
//   o_PC           out  PC_W  program ROM address
//   i_Rom_Data     in   9     ROM data, valid the cycle after o_PC is presented
//   o_Instr        out  9     instruction to register bank; 9'b0 (NOP) outside execute window
//   o_Ret_Addr     out  PC_W  PC+1, return address captured into R7 on CALL
//   i_Jump_Addr    in   8     R[RX] from register bank while op=111
//   o_Ctl_Reg      out  1     R0 <= ALU result strobe
//   o_Mem_Req      out  1     data-memory request, held until ack
//   o_Mem_We       out  1     1=write (ST/OUT), 0=read (LD); valid with o_Mem_Req
//   i_Mem_Ack      in   1     one-cycle completion; read data valid this cycle
//   o_Halted       out  1     core stopped (HALT or fault)
//   o_Fault        out  1     sticky memory-timeout flag
// BEHAVIOUR
//   Reset: o_PC=RESET_PC, o_Instr=0, o_Ctl_Reg=0, o_Mem_Req=0, o_Mem_We=0, o_Halted=0, o_Fault=0,
//     state=FETCH, IR=0, timeout counter=0. Reset mid-transaction drops o_Mem_Req the next edge.
//   States: FETCH -> DECODE -> EXEC -> {FETCH | MEM_WAIT | HALT}; MEM_WAIT -> {FETCH | HALT}.
//   FETCH: drive o_PC. DECODE: latch i_Rom_Data into IR. EXEC: o_Instr=IR for exactly that cycle.
//   op 000 NOP, 001 MOVI, 101 MOV: EXEC only, PC<=PC+1. Total 3 cycles/instr.
//   op 110 ALU: o_Ctl_Reg=1 in EXEC only; PC+1; 3 cycles.
//   op 010 LD: EXEC raises o_Mem_Req, We=0; o_Instr=IR is held through MEM_WAIT, so the bank rewrites
//     RX each cycle and the ack-cycle write is final. On ack: req drops next edge, PC+1, -> FETCH.
//   op 011 ST, 100 OUT: same handshake with We=1; o_Instr held so address/data stay stable.
//   Ack in the EXEC cycle itself is accepted (no MEM_WAIT); ack outside request is ignored.
//   op 111: RY=000 JMP: PC<=i_Jump_Addr. RY=001 CALL: o_Ret_Addr=PC+1 in EXEC, PC<=i_Jump_Addr.
//     RY=010 HALT: -> HALT, o_Halted=1. Other RY: NOP, PC+1.
//   Timeout: counter counts MEM_WAIT cycles; at MEM_TIMEOUT without ack -> o_Fault=1, o_Mem_Req=0,
//     -> HALT. HALT exits only by reset; o_Instr=0 there.
//   PC=2**PC_W-1 increments to 0. Jump target truncated/zero-extended to PC_W.
// CONFIGURATION
//   `define CTL_SINGLE_STEP_EN: adds input i_Step (1 bit); FETCH stalls until i_Step=1, one
//   instruction runs per pulse. Undefined: no port, FETCH never stalls.
// STRUCTURE
//   micro_pkg: opcode localparams (OP_NOP..OP_JMP), JMP sub-codes, state encodings, widths.
//   Sub-module ctl_watchdog: load/count/expire counter for MEM_TIMEOUT; FSM in unidad_control.
// TESTING
//   Reset then ROM {001,011,101}: o_Instr=9'h05D only in cycle 3; PC 0->1 after 3 cycles.
//   LD with ack after 4 cycles: o_Mem_Req high 5 cycles, We=0; PC+1 on ack; req low next edge.
//   ALU op 110: o_Ctl_Reg=1 exactly one cycle, coincident with o_Instr=IR.
//   CALL at PC=0x20, i_Jump_Addr=0x80: o_Ret_Addr=0x21 in EXEC; next o_PC=0x80.
//   ST, no ack for 15 cycles: o_Fault=1, o_Halted=1, req=0; stays until i_Rst.
//   NOP at PC=0xFF -> o_PC=0x00; HALT 111_xxx_010 -> o_Halted=1, o_Instr=0 thereafter.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared definitions for the 8-bit micro: instruction fields, opcodes,
// jump sub-codes and the control sequencer state encoding.
package micro_pkg;

  localparam int INSTR_W = 9;
  localparam int DATA_W  = 8;
  localparam int OP_W    = 3;

  // Opcode field instr[8:6]
  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_MOVI = 3'b001;
  localparam logic [OP_W-1:0] OP_LD   = 3'b010;
  localparam logic [OP_W-1:0] OP_ST   = 3'b011;
  localparam logic [OP_W-1:0] OP_OUT  = 3'b100;
  localparam logic [OP_W-1:0] OP_MOV  = 3'b101;
  localparam logic [OP_W-1:0] OP_ALU  = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP  = 3'b111;

  // Sub-codes carried in RY when op = OP_JMP
  localparam logic [2:0] JMP_JMP  = 3'b000;
  localparam logic [2:0] JMP_CALL = 3'b001;
  localparam logic [2:0] JMP_HALT = 3'b010;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  // Opcodes that go through the data-memory req/ack handshake
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_OUT);
  endfunction

endpackage

// File: rtl/ctl_watchdog.sv
// Data-memory timeout counter. Cleared by load, counts while count is high,
// and flags expire on the LIMIT-th counted cycle.
module ctl_watchdog #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 8
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Expire is combinational so the sequencer can leave MEM_WAIT on that same edge
  assign expire = count && (cnt == CNT_W'(LIMIT - 1));

  // Wait-cycle counter; holds once expired so it never wraps
  always_ff @(posedge i_Clk) begin
    if (i_Rst || load)        cnt <= '0;
    else if (count && !expire) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/unidad_control.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> {FETCH|MEM_WAIT|HALT}.
// Optional build macro CTL_SINGLE_STEP_EN adds i_Step; FETCH then waits for it.
module unidad_control
  import micro_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
`ifdef CTL_SINGLE_STEP_EN
  input  logic            i_Step,
`endif
  output logic [PC_W-1:0] o_PC,
  input  logic [8:0]      i_Rom_Data,
  output logic [8:0]      o_Instr,
  output logic [PC_W-1:0] o_Ret_Addr,
  input  logic [7:0]      i_Jump_Addr,
  output logic            o_Ctl_Reg,
  output logic            o_Mem_Req,
  output logic            o_Mem_We,
  input  logic            i_Mem_Ack,
  output logic            o_Halted,
  output logic            o_Fault
);

  state_t          state, nxt;
  logic [PC_W-1:0] pc, jump_tgt;
  logic [8:0]      ir;
  logic [2:0]      op, ry;
  logic            fault, step_ok, wd_expire, mem_op, mem_done;
  logic            pc_inc, pc_jump, wd_load, wd_count;

  assign op       = ir[8:6];
  assign ry       = ir[2:0];
  assign mem_op   = is_mem_op(op);
  assign mem_done = mem_op && i_Mem_Ack;
  // Register value is 8 bits; fit it to the PC width (truncate or zero-extend)
  assign jump_tgt = PC_W'(i_Jump_Addr);

`ifdef CTL_SINGLE_STEP_EN
  assign step_ok = i_Step;
`else
  assign step_ok = 1'b1;
`endif

  assign wd_load  = (state == ST_EXEC);
  assign wd_count = (state == ST_MEM_WAIT) && !i_Mem_Ack;

  ctl_watchdog #(.LIMIT(MEM_TIMEOUT)) u_watchdog (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .load   (wd_load),
    .count  (wd_count),
    .expire (wd_expire)
  );

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_FETCH;
    else       state <= nxt;
  end

  // Next-state: an ack always wins over an expiring watchdog in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      ST_FETCH:    if (step_ok) nxt = ST_DECODE;
      ST_DECODE:   nxt = ST_EXEC;
      ST_EXEC: begin
        if (mem_op)                             nxt = mem_done ? ST_FETCH : ST_MEM_WAIT;
        else if (op == OP_JMP && ry == JMP_HALT) nxt = ST_HALT;
        else                                    nxt = ST_FETCH;
      end
      ST_MEM_WAIT: begin
        if (mem_done)       nxt = ST_FETCH;
        else if (wd_expire) nxt = ST_HALT;
      end
      ST_HALT:     nxt = ST_HALT;
      default:     nxt = ST_FETCH;
    endcase
  end

  // Outputs and PC-update decode; the instruction stays on the bus for the whole memory window
  always_comb begin
    o_Instr   = '0;
    o_Ctl_Reg = 1'b0;
    o_Mem_Req = 1'b0;
    o_Mem_We  = 1'b0;
    pc_inc    = 1'b0;
    pc_jump   = 1'b0;
    case (state)
      ST_EXEC: begin
        o_Instr   = ir;
        o_Ctl_Reg = (op == OP_ALU);
        o_Mem_Req = mem_op;
        o_Mem_We  = mem_op && (op != OP_LD);
        pc_jump   = (op == OP_JMP) && (ry == JMP_JMP || ry == JMP_CALL);
        if (mem_op) pc_inc = i_Mem_Ack;
        else        pc_inc = !(op == OP_JMP && (ry == JMP_JMP || ry == JMP_CALL || ry == JMP_HALT));
      end
      ST_MEM_WAIT: begin
        o_Instr   = ir;
        o_Mem_Req = 1'b1;
        o_Mem_We  = (op != OP_LD);
        pc_inc    = i_Mem_Ack;
      end
      default: ;
    endcase
  end

  // Datapath: IR capture, PC update and sticky fault
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pc    <= PC_W'(RESET_PC);
      ir    <= '0;
      fault <= 1'b0;
    end else begin
      if (state == ST_DECODE) ir <= i_Rom_Data;
      if (pc_jump)     pc <= jump_tgt;
      else if (pc_inc) pc <= pc + PC_W'(1);
      if (state == ST_MEM_WAIT && !i_Mem_Ack && wd_expire) fault <= 1'b1;
    end
  end

  assign o_PC       = pc;
  assign o_Ret_Addr = pc + PC_W'(1);
  assign o_Halted   = (state == ST_HALT);
  assign o_Fault    = fault;

endmodule

// File: tb/tb_unidad_control.sv
// Randomized scoreboard bench for unidad_control. An instruction-level model
// walks the ROM image and queues one expected execute window per instruction;
// a monitor pops an entry each time the DUT opens a window on o_Instr.
`timescale 1ns/1ps
module tb_unidad_control;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [7:0] o_PC;
  logic [8:0] i_Rom_Data;
  logic [8:0] o_Instr;
  logic [7:0] o_Ret_Addr;
  logic [7:0] i_Jump_Addr;
  logic       o_Ctl_Reg, o_Mem_Req, o_Mem_We, i_Mem_Ack, o_Halted, o_Fault;

  unidad_control #(.PC_W(8), .RESET_PC(0), .MEM_TIMEOUT(15)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
`ifdef CTL_SINGLE_STEP_EN
    .i_Step     (1'b1),
`endif
    .o_PC       (o_PC),
    .i_Rom_Data (i_Rom_Data),
    .o_Instr    (o_Instr),
    .o_Ret_Addr (o_Ret_Addr),
    .i_Jump_Addr(i_Jump_Addr),
    .o_Ctl_Reg  (o_Ctl_Reg),
    .o_Mem_Req  (o_Mem_Req),
    .o_Mem_We   (o_Mem_We),
    .i_Mem_Ack  (i_Mem_Ack),
    .o_Halted   (o_Halted),
    .o_Fault    (o_Fault)
  );

  always #5 i_Clk = ~i_Clk;

  // Program ROM (one-cycle read latency) and register-bank stand-in for R[RX]
  logic [8:0] rom [256];
  logic [7:0] jt  [8];
  always @(posedge i_Clk) i_Rom_Data <= rom[o_PC];
  assign i_Jump_Addr = jt[o_Instr[5:3]];

  typedef struct {
    int         pc;
    logic [8:0] instr;
    int         len;    // cycles o_Instr stays non-zero
    bit         halt;
    bit         fault;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];       // per memory op: cycles after EXEC until ack (>15 = never)
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: executes instructions by their architectural meaning
  task automatic gen_run(input int n, input int to_pct, input int force_lat,
                         output bit halted, output bit faulted);
    int pc, nxt, lat, op, rx, ry;
    exp_t e;
    pc = 0; halted = 0; faulted = 0;
    for (int i = 0; i < n; i++) begin
      e.pc = pc; e.instr = rom[pc]; e.len = 1; e.halt = 0; e.fault = 0;
      op = int'(e.instr[8:6]); rx = int'(e.instr[5:3]); ry = int'(e.instr[2:0]);
      nxt = (pc + 1) % 256;
      if (op == 2 || op == 3 || op == 4) begin
        if (force_lat >= 0)                        lat = force_lat;
        else if ($urandom_range(0, 99) < to_pct)  lat = 1000;
        else begin
          lat = int'($urandom_range(0, 5));
          if (lat == 5) lat = 15;
        end
        lat_q.push_back(lat);
        if (lat > 15) begin e.len = 16; e.halt = 1; e.fault = 1; end
        else e.len = lat + 1;
      end else if (op == 7 && (ry == 0 || ry == 1)) begin
        nxt = int'(jt[rx]);
      end else if (op == 7 && ry == 2) begin
        e.halt = 1;
      end
      exp_q.push_back(e);
      if (e.halt) begin halted = 1; faulted = e.fault; break; end
      pc = nxt;
    end
  endtask

  // Memory responder: acks after the queued latency, plus stray acks when idle
  int  rsp_wait;
  bit  rsp_active;
  initial begin
    i_Mem_Ack = 1'b0; rsp_active = 0; rsp_wait = 0;
    forever begin
      @(posedge i_Clk); #1;
      i_Mem_Ack = 1'b0;
      if (!o_Mem_Req) begin
        rsp_active = 0;
        if (!i_Rst && $urandom_range(0, 4) == 0) i_Mem_Ack = 1'b1;
      end else begin
        if (!rsp_active) begin
          rsp_active = 1;
          rsp_wait = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        end
        if (rsp_wait == 0) i_Mem_Ack = 1'b1;
        else rsp_wait--;
      end
    end
  end

  // Monitor: one expected entry per execute window
  bit   mon_busy = 0, mon_have = 0, mon_first = 1;
  int   mon_cyc = 0, mon_last = 0, mon_last_len = 0, mon_wlen = 0;
  exp_t cur;
  initial begin
    forever begin
      @(negedge i_Clk); mon_cyc++;
      if (i_Rst) begin
        mon_busy = 0; mon_have = 0; mon_first = 1;
      end else if (o_Instr != 9'd0) begin
        if (!mon_busy) begin
          mon_busy = 1; mon_wlen = 0;
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front(); mon_have = 1;
            if (!mon_first) chk("cycle spacing", mon_cyc - mon_last, mon_last_len + 2);
            chk("pc", {24'd0, o_PC}, cur.pc);
            chk("ret_addr", {24'd0, o_Ret_Addr}, (cur.pc + 1) % 256);
            mon_first = 0; mon_last = mon_cyc; mon_last_len = cur.len;
          end else mon_have = 0;
        end
        mon_wlen++;
        if (mon_have) begin
          chk("instr", o_Instr, cur.instr);
          chk("ctl_reg", o_Ctl_Reg, (cur.instr[8:6] == 3'd6) && (mon_wlen == 1));
          chk("mem_req", o_Mem_Req, cur.instr[8:6] inside {3'd2, 3'd3, 3'd4});
          if (o_Mem_Req) chk("mem_we", o_Mem_We, cur.instr[8:6] != 3'd2);
        end
      end else if (mon_busy) begin
        mon_busy = 0;
        if (mon_have) begin
          chk("window length", mon_wlen, cur.len);
          chk("halted after window", o_Halted, cur.halt);
          chk("fault after window", o_Fault, cur.fault);
          chk("req low after window", o_Mem_Req, 0);
        end
        mon_have = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge i_Clk); #2;
    i_Rst = 1'b1;
    repeat (2) @(posedge i_Clk);
    #2;
    chk("rst pc", {24'd0, o_PC}, 0);
    chk("rst instr", o_Instr, 0);
    chk("rst mem_req", o_Mem_Req, 0);
    chk("rst mem_we", o_Mem_We, 0);
    chk("rst ctl_reg", o_Ctl_Reg, 0);
    chk("rst halted", o_Halted, 0);
    chk("rst fault", o_Fault, 0);
    exp_q.delete(); lat_q.delete();
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) rom[a] = 9'($urandom_range(1, 511));
    for (int r = 0; r < 8; r++)   jt[r]  = 8'($urandom_range(0, 255));
  endtask

  task automatic run(input int n, input int to_pct, input int force_lat);
    bit h, f;
    int t;
    gen_run(n, to_pct, force_lat, h, f);
    i_Rst = 1'b0;
    t = 0;
    while ((exp_q.size() > 0 || mon_busy) && t < 5000) begin
      @(posedge i_Clk); #2; t++;
    end
    chk("drain within budget", t < 5000, 1);
    if (h) repeat (4) begin
      @(posedge i_Clk); #2;
      chk("halt sticky", o_Halted, 1);
      chk("halt instr zero", o_Instr, 0);
      chk("halt req low", o_Mem_Req, 0);
      chk("fault sticky", o_Fault, f);
    end
  endtask

  initial begin
    i_Rst = 1'b1;
    for (int a = 0; a < 256; a++) rom[a] = 9'h007;
    for (int r = 0; r < 8; r++)   jt[r]  = 8'h00;

    // MOVI 001_011_101 at address 0
    do_reset(); rom[0] = 9'h05D; run(1, 0, -1);

    // LD acked four cycles after EXEC, then ALU
    do_reset(); rom[0] = 9'b010_011_000; rom[1] = 9'b110_001_010; run(2, 0, 4);

    // JMP to 0x20, CALL to 0x80, ALU, JMP to 0xFF, NOP wraps to 0
    do_reset(); fill_random();
    jt[1] = 8'h20; jt[2] = 8'h80; jt[3] = 8'hFF;
    rom[8'h00] = 9'b111_001_000; rom[8'h20] = 9'b111_010_001;
    rom[8'h80] = 9'b110_000_000; rom[8'h81] = 9'b111_011_000;
    rom[8'hFF] = 9'h007;
    run(7, 0, -1);

    // MOV then HALT
    do_reset(); rom[0] = 9'b101_001_010; rom[1] = 9'b111_100_010; run(5, 0, -1);

    // ST never acked -> timeout fault
    do_reset(); rom[0] = 9'b011_000_001; run(3, 100, -1);

    // Random programs, later ones with occasional unanswered requests
    for (int r = 0; r < 16; r++) begin
      do_reset(); fill_random(); run(40, (r >= 12) ? 15 : 0, -1);
    end

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
